// File: rtl/caf_pkg.sv
// Shared state encodings, default widths and the FOA centring helper for the CAF step generator.
package caf_pkg;

  typedef logic [1:0] caf_state_t;

  localparam caf_state_t IDLE  = 2'd0;
  localparam caf_state_t LOAD  = 2'd1;
  localparam caf_state_t SERVE = 2'd2;
  localparam caf_state_t DONE  = 2'd3;

  localparam int unsigned CAF_PHASE_BITS        = 10;
  localparam int unsigned CAF_FOAS_COUNTER_BITS = 3;

  // Index of the zero offset; even foas counts put the extra step on the positive side.
  function automatic int unsigned center_of(input int unsigned foas);
    return (foas > 0) ? (foas - 1) / 2 : 0;
  endfunction

endpackage

// File: rtl/caf_step_offset.sv
// Maps step index k and step size to a signed frequency offset (magnitude + sign).
// Optional macro CAF_STEP_SAT_EN: saturate oversized magnitudes instead of wrapping.
module caf_step_offset
  import caf_pkg::*;
#(
  parameter int unsigned phase_bits        = CAF_PHASE_BITS,
  parameter int unsigned foas              = 3,
  parameter int unsigned foas_counter_bits = CAF_FOAS_COUNTER_BITS
) (
  input  logic [foas_counter_bits-1:0] k,
  input  logic [phase_bits-1:0]        step_size,
  output logic [phase_bits-1:0]        freq_step,
  output logic                         neg_shift,
  output logic                         ovf_hit
);

  localparam int unsigned prod_bits = phase_bits + foas_counter_bits;
  localparam logic [foas_counter_bits-1:0] center = foas_counter_bits'(center_of(foas));

  logic                         neg;
  logic [foas_counter_bits-1:0] mag;
  logic [prod_bits-1:0]         prod;

  always_comb begin
    neg  = (k < center);
    mag  = neg ? (center - k) : (k - center);
    prod = prod_bits'(mag) * prod_bits'(step_size);
`ifdef CAF_STEP_SAT_EN
    ovf_hit   = |prod[prod_bits-1:phase_bits];
    freq_step = ovf_hit ? '1 : prod[phase_bits-1:0];
`else
    ovf_hit   = 1'b0;
    freq_step = prod[phase_bits-1:0];
`endif
    // A zero magnitude is never reported as a negative shift.
    neg_shift = neg && (freq_step != '0);
  end

endmodule

// File: rtl/caf_freq_step_gen.sv
// Emits foas centred frequency-offset steps per start pulse over a valid/ready handshake.
// Optional macro CAF_STEP_SAT_EN: saturating magnitudes with a sticky ovf flag.
module caf_freq_step_gen
  import caf_pkg::*;
#(
  parameter int unsigned phase_bits        = CAF_PHASE_BITS,
  parameter int unsigned foas              = 3,
  parameter int unsigned foas_counter_bits = CAF_FOAS_COUNTER_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [phase_bits-1:0]        step_size,
  output logic                         busy,
  output logic [phase_bits-1:0]        freq_step,
  output logic                         neg_shift,
  output logic                         freq_step_valid,
  input  logic                         freq_step_tready,
  output logic [foas_counter_bits-1:0] freq_step_index,
  output logic                         freq_step_last,
  output logic                         done,
  output logic                         ovf
);

  localparam logic [foas_counter_bits-1:0] last_idx = foas_counter_bits'(foas - 1);

  caf_state_t                   state_q, state_d;
  logic [foas_counter_bits-1:0] k_q, k_d, k_sel;
  logic [phase_bits-1:0]        step_q, step_d;
  logic [phase_bits-1:0]        freq_step_q, freq_step_d;
  logic                         neg_q, neg_d;
  logic                         valid_q, valid_d;
  logic                         last_q, last_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         ovf_q, ovf_d;

  logic [phase_bits-1:0] off_step;
  logic                  off_neg;
  logic                  off_ovf;
  logic                  transfer;

  caf_step_offset #(
    .phase_bits        (phase_bits),
    .foas              (foas),
    .foas_counter_bits (foas_counter_bits)
  ) u_offset (
    .k         (k_sel),
    .step_size (step_q),
    .freq_step (off_step),
    .neg_shift (off_neg),
    .ovf_hit   (off_ovf)
  );

  assign transfer = valid_q && freq_step_tready;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    k_sel       = k_q;
    step_d      = step_q;
    freq_step_d = freq_step_q;
    neg_d       = neg_q;
    valid_d     = valid_q;
    last_d      = last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          step_d  = step_size;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        k_sel       = '0;
        k_d         = '0;
        freq_step_d = off_step;
        neg_d       = off_neg;
        ovf_d       = ovf_q | off_ovf;
        valid_d     = 1'b1;
        last_d      = (last_idx == '0);
        busy_d      = 1'b1;
        state_d     = SERVE;
      end
      SERVE: begin
        if (transfer) begin
          if (k_q == last_idx) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            // Present the next entry straight away so ready-held streams run at one step/cycle.
            k_sel       = k_q + 1'b1;
            k_d         = k_sel;
            freq_step_d = off_step;
            neg_d       = off_neg;
            ovf_d       = ovf_q | off_ovf;
            last_d      = (k_sel == last_idx);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      step_q      <= '0;
      freq_step_q <= '0;
      neg_q       <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      step_q      <= step_d;
      freq_step_q <= freq_step_d;
      neg_q       <= neg_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy            = busy_q;
  assign freq_step       = freq_step_q;
  assign neg_shift       = neg_q;
  assign freq_step_valid = valid_q;
  assign freq_step_index = k_q;
  assign freq_step_last  = last_q;
  assign done            = done_q;
  assign ovf             = ovf_q;

endmodule

// File: tb/tb_caf_freq_step_gen.sv
// Directed bench for caf_freq_step_gen with foas=3, foas=4 and foas=5 instances.
module tb_caf_freq_step_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // foas=3 instance
  logic       start_a = 0, ready_a = 0;
  logic [9:0] step_a = '0, fs_a;
  logic [2:0] idx_a;
  logic       busy_a, neg_a, valid_a, last_a, done_a, ovf_a;
  // foas=4 instance
  logic       start_b = 0, ready_b = 0;
  logic [9:0] step_b = '0, fs_b;
  logic [2:0] idx_b;
  logic       busy_b, neg_b, valid_b, last_b, done_b, ovf_b;
  // foas=5 instance
  logic       start_c = 0, ready_c = 0;
  logic [9:0] step_c = '0, fs_c;
  logic [2:0] idx_c;
  logic       busy_c, neg_c, valid_c, last_c, done_c, ovf_c;

  caf_freq_step_gen #(.phase_bits(10), .foas(3), .foas_counter_bits(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .step_size(step_a), .busy(busy_a),
    .freq_step(fs_a), .neg_shift(neg_a), .freq_step_valid(valid_a),
    .freq_step_tready(ready_a), .freq_step_index(idx_a), .freq_step_last(last_a),
    .done(done_a), .ovf(ovf_a)
  );
  caf_freq_step_gen #(.phase_bits(10), .foas(4), .foas_counter_bits(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .step_size(step_b), .busy(busy_b),
    .freq_step(fs_b), .neg_shift(neg_b), .freq_step_valid(valid_b),
    .freq_step_tready(ready_b), .freq_step_index(idx_b), .freq_step_last(last_b),
    .done(done_b), .ovf(ovf_b)
  );
  caf_freq_step_gen #(.phase_bits(10), .foas(5), .foas_counter_bits(3)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .step_size(step_c), .busy(busy_c),
    .freq_step(fs_c), .neg_shift(neg_c), .freq_step_valid(valid_c),
    .freq_step_tready(ready_c), .freq_step_index(idx_c), .freq_step_last(last_c),
    .done(done_c), .ovf(ovf_c)
  );

  int xfer_a = 0;
  always @(posedge clk) if (valid_a && ready_a) xfer_a <= xfer_a + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hand-computed beat tables
  int unsigned fs3_tbl [3] = '{100, 0, 100};
  int unsigned ng3_tbl [3] = '{1, 0, 0};
  int unsigned fs4_tbl [4] = '{7, 0, 7, 14};
  int unsigned ng4_tbl [4] = '{1, 0, 0, 0};
`ifdef CAF_STEP_SAT_EN
  int unsigned fs5_tbl [5] = '{1023, 600, 0, 600, 1023};
  int unsigned ovf5 = 1;
`else
  int unsigned fs5_tbl [5] = '{176, 600, 0, 600, 176};
  int unsigned ovf5 = 0;
`endif
  int unsigned ng5_tbl [5] = '{1, 1, 0, 0, 0};
  logic        pat [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int exp_k;
    int x0;
    bit seen;

    // Reset state
    tick(); tick();
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_fs", fs_a, 0);
    chk("rst_idx", idx_a, 0);
    chk("rst_done", done_a, 0);
    rst = 0;
    tick();

    // foas=3, step 100, ready held high from before valid
    ready_a = 1; step_a = 10'd100; start_a = 1;
    tick();
    start_a = 0;
    chk("t1_load_valid", valid_a, 0);
    chk("t1_load_busy", busy_a, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t1_valid_k%0d", k), valid_a, 1);
      chk($sformatf("t1_fs_k%0d", k), fs_a, fs3_tbl[k]);
      chk($sformatf("t1_neg_k%0d", k), neg_a, ng3_tbl[k]);
      chk($sformatf("t1_idx_k%0d", k), idx_a, k);
      chk($sformatf("t1_last_k%0d", k), last_a, (k == 2) ? 1 : 0);
      tick();
    end
    chk("t1_done", done_a, 1);
    chk("t1_valid_after", valid_a, 0);
    chk("t1_busy_after", busy_a, 0);
    tick();
    chk("t1_done_pulse", done_a, 0);
    ready_a = 0;

    // foas=3 with stalls, and a start re-pulse during SERVE that must be ignored
    step_a = 10'd100; start_a = 1;
    tick();
    start_a = 0;
    tick();
    x0 = xfer_a;
    exp_k = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_valid_c%0d", i), valid_a, 1);
      chk($sformatf("t2_idx_c%0d", i), idx_a, exp_k);
      chk($sformatf("t2_fs_c%0d", i), fs_a, fs3_tbl[exp_k]);
      chk($sformatf("t2_neg_c%0d", i), neg_a, ng3_tbl[exp_k]);
      ready_a = pat[i];
      if (i == 1) begin
        start_a = 1; step_a = 10'd55;
      end else begin
        start_a = 0;
      end
      tick();
      if (pat[i]) exp_k++;
    end
    start_a = 0; ready_a = 0;
    chk("t2_xfers", xfer_a - x0, 3);
    chk("t2_done", done_a, 1);
    tick();

    // foas=4, step 7
    ready_b = 1; step_b = 10'd7; start_b = 1;
    tick();
    start_b = 0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_fs_k%0d", k), fs_b, fs4_tbl[k]);
      chk($sformatf("t3_neg_k%0d", k), neg_b, ng4_tbl[k]);
      chk($sformatf("t3_idx_k%0d", k), idx_b, k);
      chk($sformatf("t3_last_k%0d", k), last_b, (k == 3) ? 1 : 0);
      tick();
    end
    chk("t3_done", done_b, 1);
    tick();

    // foas=5, step 600: saturate or wrap depending on build
    ready_c = 1; step_c = 10'd600; start_c = 1;
    tick();
    start_c = 0;
    tick();
    chk("t4_ovf_k0", ovf_c, ovf5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_fs_k%0d", k), fs_c, fs5_tbl[k]);
      chk($sformatf("t4_neg_k%0d", k), neg_c, ng5_tbl[k]);
      tick();
    end
    chk("t4_done", done_c, 1);
    chk("t4_ovf_sticky", ovf_c, ovf5);
    tick();
    chk("t4_ovf_held", ovf_c, ovf5);
    step_c = 10'd1; start_c = 1;
    tick();
    start_c = 0;
    chk("t4_ovf_cleared", ovf_c, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (done_c) seen = 1;
    end
    chk("t4_rerun_done", seen, 1);
    chk("t4_rerun_ovf", ovf_c, 0);

    // Reset asserted at the second beat of a foas=3 run
    ready_a = 1; step_a = 10'd100; start_a = 1;
    tick();
    start_a = 0;
    tick();
    tick();
    chk("t5_pre_idx", idx_a, 1);
    #2 rst = 1;
    #1;
    chk("t5_rst_valid", valid_a, 0);
    chk("t5_rst_busy", busy_a, 0);
    chk("t5_rst_idx", idx_a, 0);
    chk("t5_rst_fs", fs_a, 0);
    tick();
    rst = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_a || valid_a) seen = 1;
    end
    chk("t5_no_done", seen, 0);
    step_a = 10'd100; start_a = 1;
    tick();
    start_a = 0;
    tick();
    chk("t5_clean_idx", idx_a, 0);
    chk("t5_clean_fs", fs_a, 100);
    chk("t5_clean_neg", neg_a, 1);
    tick(); tick(); tick();
    chk("t5_clean_done", done_a, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/caf_freq_step_gen.md
Name: caf_freq_step_gen

Overview:
Master-side source of frequency-offset (FOA) steps for the CAF top. It takes one step size and emits `foas` phase increments, centred on zero, each with a neg_shift flag and its index. The stream feeds the CAF's freq_step/neg_shift/valid loading handshake. It runs once per start pulse, before correlation begins.

Parameters:
- phase_bits, 10, width of the phase-increment magnitude.
- foas, 3, number of frequency offsets generated per run.
- foas_counter_bits, 3, width of freq_step_index; must satisfy 2^foas_counter_bits >= foas.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle pulse that latches step_size and begins a run.
- step_size, input, phase_bits, phase increment between adjacent FOAs; sampled only with start.
- busy, output, 1, high from the cycle after an accepted start until done.
- freq_step, output, phase_bits, magnitude of the current offset.
- neg_shift, output, 1, current offset is negative.
- freq_step_valid, output, 1, freq_step, neg_shift, index and last are valid.
- freq_step_tready, input, 1, consumer accepts the current step.
- freq_step_index, output, foas_counter_bits, index k of the current step, 0..foas-1.
- freq_step_last, output, 1, current step is index foas-1.
- done, output, 1, one-cycle pulse after the last transfer.
- ovf, output, 1, sticky flag: some magnitude exceeded phase_bits; cleared by start.

Behaviour:
- Reset (async, any state): every output is 0, the state machine goes to IDLE, the index counter is 0 and latched step_size is 0. An in-flight run is abandoned and no done pulse is issued.
- States are IDLE, LOAD, SERVE, DONE.
- IDLE: start=1 latches step_size, clears ovf and moves to LOAD. In every other state start is ignored.
- LOAD: one cycle. Compute the entry for k=0 into the output registers, set valid=1 and busy=1, then move to SERVE. The first valid appears 2 cycles after start.
- SERVE: a transfer happens when valid && tready.
  - While valid && !tready, all outputs hold stable.
  - On a transfer with k<foas-1, the entry for k+1 is presented the next cycle with valid kept high, so back-to-back transfers give 1 step/cycle.
  - On a transfer with k=foas-1, valid drops to 0 the next cycle and the machine moves to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Arithmetic:
  - center = floor((foas-1)/2).
  - signed offset d = k - center, so foas=3 gives -1,0,+1 and foas=4 gives -1,0,+1,+2.
  - freq_step = |d| * step_size. The product is computed at width phase_bits + foas_counter_bits and then reduced to phase_bits (see Optional Feature).
  - neg_shift = (d<0). When d=0 or step_size=0, neg_shift=0 is forced whenever freq_step==0.
- freq_step_last = valid && k==foas-1.
- foas=1: a single step is emitted with d=0, freq_step=0, last=1.
- tready held high before valid has no effect; no transfer is counted until valid.

Optional Feature:
- Macro: CAF_STEP_SAT_EN.
- Defined: a product above 2^phase_bits-1 saturates freq_step to all ones and sets ovf. ovf holds until the next accepted start or reset.
- Undefined: the product wraps modulo 2^phase_bits and ovf is tied to 0.

Decomposition:
- Package caf_pkg holds:
  - the state encodings IDLE/LOAD/SERVE/DONE as a 2-bit typedef;
  - default widths for phase_bits and foas_counter_bits;
  - a function that computes center from foas.
- Sub-module caf_step_offset: combinational. It maps (k, step_size) to (freq_step, neg_shift, ovf_hit) and holds the saturate/wrap logic. The top keeps the FSM, counter and registers.

Test Plan:
- foas=3, step_size=100, tready=1 constant, start pulse -> valid first asserted 2 cycles after start; 3 consecutive beats (100,neg=1,k=0),(0,neg=0,k=1),(100,neg=0,k=2,last=1); done 1 cycle after the last beat.
- Same run with tready toggled 0,1,0,0,1,1 -> every beat holds stable while stalled; exactly 3 transfers occur; no duplicated or skipped index.
- foas=4, step_size=7 -> sequence (7,neg),(0),(7),(14,last); neg_shift high only on k=0.
- phase_bits=10, foas=5, step_size=600, CAF_STEP_SAT_EN defined -> k=0 and k=4 give 1023 and ovf=1. Without the macro they give 176 (1200 mod 1024) and ovf=0.
- Assert rst at the second beat of a foas=3 run -> all outputs are 0 immediately, with no done pulse. A start after reset release gives a clean run from k=0.
- start re-pulsed during SERVE with a different step_size -> ignored; the run completes with the original step_size values.
